// File: rtl/alu_arb_if.sv
// Bundle between two requesters, the shared ALU and the response consumer of alu_arb.
// master: the environment side (requesters, ALU, consumer); slave: the arbiter.
interface alu_arb_if;
    logic        req0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [3:0]  op0;
    logic        req1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [3:0]  op1;
    logic        gnt0;
    logic        gnt1;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_c;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_c;
    logic        rsp_zero;
    logic        rsp_ready;
    logic        busy;

    modport master (
        output req0, a0, b0, op0, req1, a1, b1, op1, alu_c, alu_zero, rsp_ready,
        input  gnt0, gnt1, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_c, rsp_zero, busy
    );

    modport slave (
        input  req0, a0, b0, op0, req1, a1, b1, op1, alu_c, alu_zero, rsp_ready,
        output gnt0, gnt1, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_c, rsp_zero, busy
    );
endinterface

// File: rtl/alu_arb.sv
// Two-port arbiter in front of one shared combinational ALU.
// IDLE accepts a request and latches its operands, EXEC drives the ALU from those
// registers and captures the result, RESP holds the result until rsp_ready.
// Build option: define ALU_ARB_RR_EN for round-robin on contention; otherwise
// port 0 has fixed priority.
module alu_arb (
    input logic      clk,
    input logic      rst,
    alu_arb_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] a_q, b_q, c_q;
    logic [3:0]  op_q;
    logic        id_q, zero_q;
    logic        gnt0_q, gnt1_q;
    logic        accept;
    logic        win;

    assign accept = (state_q == IDLE) && (bus.req0 || bus.req1);

`ifdef ALU_ARB_RR_EN
    logic ptr_q;

    // On contention grant the port that did not win last; a lone request always wins.
    always_comb begin
        if (bus.req0 && bus.req1) begin
            win = ~ptr_q;
        end else begin
            win = ~bus.req0;
        end
    end

    // Last-winner pointer moves only when a request is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b1;
        end else if (accept) begin
            ptr_q <= win;
        end
    end
`else
    // Fixed priority: port 1 wins only when port 0 is not requesting.
    assign win = ~bus.req0;
`endif

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the winner's operands and id on acceptance; the ALU sees only these.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            op_q <= 4'd0;
            id_q <= 1'b0;
        end else if (accept) begin
            a_q  <= win ? bus.a1  : bus.a0;
            b_q  <= win ? bus.b1  : bus.b0;
            op_q <= win ? bus.op1 : bus.op0;
            id_q <= win;
        end
    end

    // Grant pulses cover exactly the EXEC cycle that follows acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
        end else begin
            gnt0_q <= accept && !win;
            gnt1_q <= accept && win;
        end
    end

    // Capture the ALU result at the end of EXEC; held through RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_q    <= 32'd0;
            zero_q <= 1'b0;
        end else if (state_q == EXEC) begin
            c_q    <= bus.alu_c;
            zero_q <= bus.alu_zero;
        end
    end

    // Output drive, all from registers.
    always_comb begin
        bus.gnt0      = gnt0_q;
        bus.gnt1      = gnt1_q;
        bus.alu_a     = a_q;
        bus.alu_b     = b_q;
        bus.alu_op    = op_q;
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_id    = id_q;
        bus.rsp_c     = c_q;
        bus.rsp_zero  = zero_q;
        bus.busy      = (state_q != IDLE);
    end
endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: directed scenarios plus a randomized run against
// a transaction-level model of the arbitration and ALU behaviour.
module tb_alu_arb;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   last = 1;

    alu_arb_if bus ();

    alu_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            default: return a;
        endcase
    endfunction

    // Shared ALU model.
    assign bus.alu_c    = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
    assign bus.alu_zero = (bus.alu_c == 32'd0);

    // Winner rule: lone request wins; contention goes to port 0 or alternates.
    function automatic int pick(input bit r0, input bit r1, input int lw);
        if (r0 && r1) return RR ? 1 - lw : 0;
        return r0 ? 0 : 1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.a0 = 32'd0; bus.b0 = 32'd0; bus.op0 = 4'd0;
        bus.req1 = 1'b0; bus.a1 = 32'd0; bus.b1 = 32'd0; bus.op1 = 4'd0;
        bus.rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        last = 1;
        cyc();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        cyc();
        cyc();
        total++; if ({bus.gnt0, bus.gnt1} !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", {bus.gnt0, bus.gnt1}); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        total++; if ({bus.rsp_id, bus.rsp_zero, bus.busy} !== 3'b000) begin bad++; $display("FAIL reset_id_zero_busy got=%b exp=000", {bus.rsp_id, bus.rsp_zero, bus.busy}); end
        total++; if (bus.rsp_c !== 32'd0) begin bad++; $display("FAIL reset_rsp_c got=%h exp=0", bus.rsp_c); end
        total++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 68'd0) begin bad++; $display("FAIL reset_alu got=%h exp=0", {bus.alu_a, bus.alu_b, bus.alu_op}); end
        rst = 1'b1;
        last = 1;
        cyc();
    endtask

    task automatic test_add();
        bus.req0 = 1'b1; bus.a0 = 32'd5; bus.b0 = 32'd3; bus.op0 = OP_ADD;
        bus.rsp_ready = 1'b1;
        cyc();
        total++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin bad++; $display("FAIL add_gnt got=%b exp=10", {bus.gnt0, bus.gnt1}); end
        total++; if ({bus.rsp_valid, bus.busy} !== 2'b01) begin bad++; $display("FAIL add_exec_valid_busy got=%b exp=01", {bus.rsp_valid, bus.busy}); end
        total++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {32'd5, 32'd3, OP_ADD}) begin bad++; $display("FAIL add_alu_drive got=%h exp=%h", {bus.alu_a, bus.alu_b, bus.alu_op}, {32'd5, 32'd3, OP_ADD}); end
        bus.req0 = 1'b0;
        last = 0;
        cyc();
        total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL add_rsp_valid got=%b exp=1", bus.rsp_valid); end
        total++; if (bus.rsp_c !== 32'd8) begin bad++; $display("FAIL add_rsp_c got=%0d exp=8", bus.rsp_c); end
        total++; if ({bus.rsp_zero, bus.rsp_id, bus.gnt0} !== 3'b000) begin bad++; $display("FAIL add_zero_id_gnt got=%b exp=000", {bus.rsp_zero, bus.rsp_id, bus.gnt0}); end
        cyc();
        total++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin bad++; $display("FAIL add_back_idle got=%b exp=00", {bus.rsp_valid, bus.busy}); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.req0 = 1'b1; bus.a0 = 32'd7;    bus.b0 = 32'd7;    bus.op0 = OP_SUB;
        bus.req1 = 1'b1; bus.a1 = 32'hF0;   bus.b1 = 32'h0F;   bus.op1 = OP_XOR;
        bus.rsp_ready = 1'b1;
        cyc();
        total++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin bad++; $display("FAIL sim_first_gnt got=%b exp=10", {bus.gnt0, bus.gnt1}); end
        bus.req0 = 1'b0;
        cyc();
        total++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero} !== 3'b101) begin bad++; $display("FAIL sim_first_rsp got=%b exp=101", {bus.rsp_valid, bus.rsp_id, bus.rsp_zero}); end
        total++; if (bus.rsp_c !== 32'd0) begin bad++; $display("FAIL sim_first_c got=%h exp=0", bus.rsp_c); end
        cyc();
        cyc();
        total++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin bad++; $display("FAIL sim_second_gnt got=%b exp=01", {bus.gnt0, bus.gnt1}); end
        bus.req1 = 1'b0;
        cyc();
        total++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero} !== 3'b110) begin bad++; $display("FAIL sim_second_rsp got=%b exp=110", {bus.rsp_valid, bus.rsp_id, bus.rsp_zero}); end
        total++; if (bus.rsp_c !== 32'hFF) begin bad++; $display("FAIL sim_second_c got=%h exp=ff", bus.rsp_c); end
        last = 1;
        cyc();
    endtask

    task automatic test_backpressure();
        bus.req1 = 1'b1; bus.a1 = 32'h1; bus.b1 = 32'h2; bus.op1 = OP_OR;
        cyc();
        total++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin bad++; $display("FAIL bp_gnt1 got=%b exp=01", {bus.gnt0, bus.gnt1}); end
        bus.req1 = 1'b0;
        bus.req0 = 1'b1; bus.a0 = 32'd10; bus.b0 = 32'd20; bus.op0 = OP_ADD;
        bus.rsp_ready = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            total++; if ({bus.rsp_valid, bus.rsp_id, bus.gnt0, bus.gnt1} !== 4'b1100) begin bad++; $display("FAIL bp_hold_flags cycle=%0d got=%b exp=1100", i, {bus.rsp_valid, bus.rsp_id, bus.gnt0, bus.gnt1}); end
            total++; if (bus.rsp_c !== 32'd3) begin bad++; $display("FAIL bp_hold_c cycle=%0d got=%h exp=3", i, bus.rsp_c); end
            if (i < 4) cyc();
        end
        bus.rsp_ready = 1'b1;
        cyc();
        total++; if ({bus.rsp_valid, bus.busy, bus.gnt0} !== 3'b000) begin bad++; $display("FAIL bp_idle got=%b exp=000", {bus.rsp_valid, bus.busy, bus.gnt0}); end
        cyc();
        total++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin bad++; $display("FAIL bp_gnt0_after got=%b exp=10", {bus.gnt0, bus.gnt1}); end
        bus.req0 = 1'b0;
        cyc();
        total++; if ({bus.rsp_valid, bus.rsp_id} !== 2'b10 || bus.rsp_c !== 32'd30) begin bad++; $display("FAIL bp_second_rsp got=%b/%0d exp=10/30", {bus.rsp_valid, bus.rsp_id}, bus.rsp_c); end
        last = 0;
        cyc();
    endtask

    task automatic test_reset_exec();
        bus.req1 = 1'b1; bus.a1 = 32'd1; bus.b1 = 32'd1; bus.op1 = OP_ADD;
        cyc();
        total++; if ({bus.gnt1, bus.busy} !== 2'b11) begin bad++; $display("FAIL rexec_in_exec got=%b exp=11", {bus.gnt1, bus.busy}); end
        bus.req1 = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++; if ({bus.busy, bus.gnt1} !== 2'b00) begin bad++; $display("FAIL rexec_async got=%b exp=00", {bus.busy, bus.gnt1}); end
        cyc();
        total++; if ({bus.gnt0, bus.gnt1, bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.busy} !== 6'd0) begin bad++; $display("FAIL rexec_flags got=%b exp=000000", {bus.gnt0, bus.gnt1, bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.busy}); end
        total++; if ({bus.rsp_c, bus.alu_a, bus.alu_b, bus.alu_op} !== 100'd0) begin bad++; $display("FAIL rexec_data got=%h exp=0", {bus.rsp_c, bus.alu_a, bus.alu_b, bus.alu_op}); end
        rst = 1'b1;
        last = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin bad++; $display("FAIL rexec_no_rsp cycle=%0d got=%b exp=00", i, {bus.rsp_valid, bus.busy}); end
        end
    endtask

    task automatic test_arbitration();
        int k;
        int waited;
        do_reset();
        bus.req0 = 1'b1; bus.a0 = 32'd2; bus.b0 = 32'd2; bus.op0 = OP_ADD;
        bus.req1 = 1'b1; bus.a1 = 32'd9; bus.b1 = 32'd4; bus.op1 = OP_SUB;
        bus.rsp_ready = 1'b1;
        k = 0;
        waited = 0;
        while (k < 6 && waited < 40) begin
            cyc();
            waited++;
            total++; if (bus.gnt0 && bus.gnt1) begin bad++; $display("FAIL arb_both_gnt got=11 exp=not 11"); end
            if (bus.gnt0 || bus.gnt1) begin
                total++; if (int'(bus.gnt1) !== (RR ? k % 2 : 0)) begin bad++; $display("FAIL arb_order op=%0d got=%0d exp=%0d", k, bus.gnt1, RR ? k % 2 : 0); end
                k++;
            end
        end
        total++; if (k != 6) begin bad++; $display("FAIL arb_count got=%0d exp=6", k); end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        do_reset();
    endtask

    task automatic test_random();
        bit          pend[2];
        logic [31:0] pa[2], pb[2], exp_c;
        logic [3:0]  po[2];
        int          w, tries;
        bit          rdy;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int it = 0; it < 200; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p] = 1'b1;
                    pa[p] = $urandom();
                    pb[p] = ($urandom_range(0, 3) == 0) ? pa[p] : $urandom();
                    po[p] = 4'($urandom_range(0, 7));
                end
            end
            bus.req0 = pend[0]; bus.a0 = pa[0]; bus.b0 = pb[0]; bus.op0 = po[0];
            bus.req1 = pend[1]; bus.a1 = pa[1]; bus.b1 = pb[1]; bus.op1 = po[1];
            bus.rsp_ready = 1'($urandom_range(0, 1));
            if (!pend[0] && !pend[1]) begin
                cyc();
                total++; if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b000) begin bad++; $display("FAIL rnd_idle it=%0d got=%b exp=000", it, {bus.gnt0, bus.gnt1, bus.busy}); end
                continue;
            end
            w = pick(pend[0], pend[1], last);
            last = w;
            exp_c = alu_fn(pa[w], pb[w], po[w]);
            cyc();
            total++; if ({bus.gnt0, bus.gnt1} !== {w == 0, w == 1}) begin bad++; $display("FAIL rnd_gnt it=%0d got=%b exp=%b", it, {bus.gnt0, bus.gnt1}, {w == 0, w == 1}); end
            total++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {pa[w], pb[w], po[w]}) begin bad++; $display("FAIL rnd_alu it=%0d got=%h exp=%h", it, {bus.alu_a, bus.alu_b, bus.alu_op}, {pa[w], pb[w], po[w]}); end
            pend[w] = 1'b0;
            if (w == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
            cyc();
            total++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero} !== {1'b1, 1'(w), exp_c == 32'd0}) begin bad++; $display("FAIL rnd_rsp it=%0d got=%b exp=%b", it, {bus.rsp_valid, bus.rsp_id, bus.rsp_zero}, {1'b1, 1'(w), exp_c == 32'd0}); end
            total++; if (bus.rsp_c !== exp_c) begin bad++; $display("FAIL rnd_c it=%0d got=%h exp=%h", it, bus.rsp_c, exp_c); end
            tries = 0;
            do begin
                rdy = (tries >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
                bus.rsp_ready = rdy;
                cyc();
                tries++;
                if (rdy) begin
                    total++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin bad++; $display("FAIL rnd_release it=%0d got=%b exp=00", it, {bus.rsp_valid, bus.busy}); end
                end else begin
                    total++; if ({bus.rsp_valid, bus.rsp_id, bus.gnt0, bus.gnt1} !== {1'b1, 1'(w), 2'b00} || bus.rsp_c !== exp_c) begin bad++; $display("FAIL rnd_hold it=%0d got=%b/%h exp=%b/%h", it, {bus.rsp_valid, bus.rsp_id, bus.gnt0, bus.gnt1}, bus.rsp_c, {1'b1, 1'(w), 2'b00}, exp_c); end
                end
            end while (!rdy);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_simultaneous();
        test_backpressure();
        test_reset_exec();
        test_arbitration();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: req0  input  1  port-0 request; a0/b0  input  32  operands; op0  input  4  ALUop code.
REQ-004 SHALL have ports: req1  input  1  port-1 request; a1/b1  input  32  operands; op1  input  4  ALUop code.
REQ-005 SHALL have ports: gnt0/gnt1  output  1  one-cycle pulse, request of that port accepted.
REQ-006 SHALL have ports: alu_a/alu_b  output  32  and alu_op  output  4  drive the shared ALU.
REQ-007 SHALL have ports: alu_c  input  32  and alu_zero  input  1  ALU result and zero flag.
REQ-008 SHALL have ports: rsp_valid  output  1; rsp_id  output  1  winning port; rsp_c  output  32; rsp_zero  output  1.
REQ-009 SHALL have ports: rsp_ready  input  1  consumer accepts response; busy  output  1  state != IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-011 IDLE: if req0 or req1 is high at a clock edge, SHALL latch winner's a/b/op into operand registers, latch winner id, and go to EXEC; else stay IDLE.
REQ-012 SHALL assert the winner's gnt for exactly the first EXEC cycle; it SHALL never assert both gnt0 and gnt1.
REQ-013 alu_a/alu_b/alu_op SHALL be driven only from operand registers, never combinationally from requester inputs.
REQ-014 EXEC: SHALL capture alu_c into rsp_c and alu_zero into rsp_zero at the clock edge, then go to RESP.
REQ-015 RESP: rsp_valid SHALL be high; rsp_c, rsp_zero, rsp_id SHALL be held stable until rsp_ready is sampled high.
REQ-016 RESP with rsp_ready high SHALL return to IDLE; rsp_valid low the next cycle.
REQ-017 Latency: request sampled in IDLE at edge N -> gnt high cycle N+1 -> rsp_valid high from cycle N+2; minimum 3 cycles per operation.
REQ-018 No request SHALL be accepted in EXEC or RESP; requesters hold req and operands until their gnt.
REQ-019 A req dropped before acceptance SHALL be ignored without side effect.
REQ-020 Arbitration with both requests: see REQ-026/REQ-027; single request SHALL always win.
REQ-021 Op codes SHALL pass through unchanged; decoding is the ALU's concern.
REQ-022 busy SHALL be high in EXEC and RESP.

Reset
REQ-023 rst low SHALL force IDLE immediately, from any state, discarding any in-flight operation.
REQ-024 Reset values: gnt0=gnt1=0, rsp_valid=0, rsp_id=0, rsp_c=0, rsp_zero=0, alu_a=alu_b=0, alu_op=0, busy=0, last-winner pointer=1.
REQ-025 First request sampled after rst release SHALL be handled normally.

Configuration
REQ-026 Macro ALU_ARB_RR_EN defined: round-robin; on simultaneous requests grant the port not equal to last-winner pointer; pointer updates only on a grant.
REQ-027 ALU_ARB_RR_EN undefined: fixed priority, port 0 always wins simultaneous requests; pointer logic absent.

Verification
REQ-028 Port0 ADD a0=5 b0=3 -> gnt0 cycle N+1, rsp_valid N+2, rsp_c=8, rsp_zero=0, rsp_id=0.
REQ-029 Simultaneous after reset: port0 SUB 7-7, port1 XOR 0xF0^0x0F, rsp_ready=1 -> first rsp_id=0 rsp_c=0 rsp_zero=1; then rsp_id=1 rsp_c=0xFF.
REQ-030 Backpressure: port1 OR 0x1|0x2, rsp_ready low 4 cycles -> rsp_valid and rsp_c=3 stable 4 cycles, no gnt while req0 high, returns IDLE one cycle after rsp_ready high.
REQ-031 rst asserted during EXEC -> next cycle all outputs at reset values, no rsp_valid for discarded op.
REQ-032 ALU_ARB_RR_EN defined, req0 and req1 held high 6 operations -> grants alternate 0,1,0,1,0,1; undefined -> all six to port 0.
